// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline boundary: valid/ready handshake with a one-entry skid
// buffer, synchronous flush, precomputed write-back data, gated register-file
// write enable, EX bypass port and a retired-instruction counter.
module mem_wb_skid_stage #(
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned IW    = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_alu_c,
  input  logic [DW-1:0]    in_dm_data,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_regw,
  input  logic             in_mem2r,
  input  logic [IW-1:0]    in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_alu_c,
  output logic [DW-1:0]    out_dm_data,
  output logic [RW-1:0]    out_rd,
  output logic             out_regw,
  output logic             out_mem2r,
  output logic [IW-1:0]    out_instr,
  output logic [DW-1:0]    out_wb_data,
  output logic             rf_we,
  output logic             fwd_valid,
  output logic [RW-1:0]    fwd_rd,
  output logic [DW-1:0]    fwd_data,
  output logic [CNT_W-1:0] retired_cnt
);

  // Output-register state
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_alu_c_q, out_alu_c_d;
  logic [DW-1:0] out_dm_data_q, out_dm_data_d;
  logic [RW-1:0] out_rd_q, out_rd_d;
  logic          out_regw_q, out_regw_d;
  logic          out_mem2r_q, out_mem2r_d;
  logic [IW-1:0] out_instr_q, out_instr_d;
  logic [DW-1:0] out_wb_data_q, out_wb_data_d;

  // Skid-register state (always younger than OUT)
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_alu_c_q, skid_alu_c_d;
  logic [DW-1:0] skid_dm_data_q, skid_dm_data_d;
  logic [RW-1:0] skid_rd_q, skid_rd_d;
  logic          skid_regw_q, skid_regw_d;
  logic          skid_mem2r_q, skid_mem2r_d;
  logic [IW-1:0] skid_instr_q, skid_instr_d;
  logic [DW-1:0] skid_wb_data_q, skid_wb_data_d;

  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  logic          acc, pop;
  logic [DW-1:0] in_wb_data;

  // Next-state: load OUT from input or SKID, spill into SKID, drain, or flush
  always_comb begin
    out_valid_d    = out_valid_q;
    out_alu_c_d    = out_alu_c_q;
    out_dm_data_d  = out_dm_data_q;
    out_rd_d       = out_rd_q;
    out_regw_d     = out_regw_q;
    out_mem2r_d    = out_mem2r_q;
    out_instr_d    = out_instr_q;
    out_wb_data_d  = out_wb_data_q;
    skid_valid_d   = skid_valid_q;
    skid_alu_c_d   = skid_alu_c_q;
    skid_dm_data_d = skid_dm_data_q;
    skid_rd_d      = skid_rd_q;
    skid_regw_d    = skid_regw_q;
    skid_mem2r_d   = skid_mem2r_q;
    skid_instr_d   = skid_instr_q;
    skid_wb_data_d = skid_wb_data_q;

    acc        = in_valid & in_ready_q;
    pop        = out_valid_q & out_ready;
    in_wb_data = in_mem2r ? in_dm_data : in_alu_c;

    // WB sampled a popped entry this cycle, so it retires even under flush
    retired_cnt_d = retired_cnt_q + CNT_W'(pop);

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      // in_ready is low while SKID is full, so no accept can collide here
      out_alu_c_d   = skid_alu_c_q;
      out_dm_data_d = skid_dm_data_q;
      out_rd_d      = skid_rd_q;
      out_regw_d    = skid_regw_q;
      out_mem2r_d   = skid_mem2r_q;
      out_instr_d   = skid_instr_q;
      out_wb_data_d = skid_wb_data_q;
      skid_valid_d  = 1'b0;
    end else if (acc && (!out_valid_q || pop)) begin
      out_valid_d   = 1'b1;
      out_alu_c_d   = in_alu_c;
      out_dm_data_d = in_dm_data;
      out_rd_d      = in_rd;
      out_regw_d    = in_regw;
      out_mem2r_d   = in_mem2r;
      out_instr_d   = in_instr;
      out_wb_data_d = in_wb_data;
    end else if (acc) begin
      skid_valid_d   = 1'b1;
      skid_alu_c_d   = in_alu_c;
      skid_dm_data_d = in_dm_data;
      skid_rd_d      = in_rd;
      skid_regw_d    = in_regw;
      skid_mem2r_d   = in_mem2r;
      skid_instr_d   = in_instr;
      skid_wb_data_d = in_wb_data;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_alu_c_q    <= '0;
      out_dm_data_q  <= '0;
      out_rd_q       <= '0;
      out_regw_q     <= 1'b0;
      out_mem2r_q    <= 1'b0;
      out_instr_q    <= '0;
      out_wb_data_q  <= '0;
      skid_valid_q   <= 1'b0;
      skid_alu_c_q   <= '0;
      skid_dm_data_q <= '0;
      skid_rd_q      <= '0;
      skid_regw_q    <= 1'b0;
      skid_mem2r_q   <= 1'b0;
      skid_instr_q   <= '0;
      skid_wb_data_q <= '0;
      in_ready_q     <= 1'b1;
      retired_cnt_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_alu_c_q    <= out_alu_c_d;
      out_dm_data_q  <= out_dm_data_d;
      out_rd_q       <= out_rd_d;
      out_regw_q     <= out_regw_d;
      out_mem2r_q    <= out_mem2r_d;
      out_instr_q    <= out_instr_d;
      out_wb_data_q  <= out_wb_data_d;
      skid_valid_q   <= skid_valid_d;
      skid_alu_c_q   <= skid_alu_c_d;
      skid_dm_data_q <= skid_dm_data_d;
      skid_rd_q      <= skid_rd_d;
      skid_regw_q    <= skid_regw_d;
      skid_mem2r_q   <= skid_mem2r_d;
      skid_instr_q   <= skid_instr_d;
      skid_wb_data_q <= skid_wb_data_d;
      in_ready_q     <= in_ready_d;
      retired_cnt_q  <= retired_cnt_d;
    end
  end

  // Invalid entries never write the register file, and r0 is never written
  assign rf_we = out_valid_q & out_regw_q & (out_rd_q != '0);

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_alu_c   = out_alu_c_q;
  assign out_dm_data = out_dm_data_q;
  assign out_rd      = out_rd_q;
  assign out_regw    = out_regw_q;
  assign out_mem2r   = out_mem2r_q;
  assign out_instr   = out_instr_q;
  assign out_wb_data = out_wb_data_q;
  assign fwd_valid   = rf_we;
  assign fwd_rd      = out_rd_q;
  assign fwd_data    = out_wb_data_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage; the reference model is a
// two-deep FIFO of instructions plus a modulo-16 retire counter.
module tb_mem_wb_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned IW = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned VW = 180;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, in_regw, in_mem2r;
  logic [DW-1:0] in_alu_c, in_dm_data;
  logic [RW-1:0] in_rd;
  logic [IW-1:0] in_instr;
  logic out_valid, out_ready, out_regw, out_mem2r, rf_we, fwd_valid;
  logic [DW-1:0] out_alu_c, out_dm_data, out_wb_data, fwd_data;
  logic [RW-1:0] out_rd, fwd_rd;
  logic [IW-1:0] out_instr;
  logic [CNT_W-1:0] retired_cnt;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(.DW(DW), .RW(RW), .IW(IW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_c(in_alu_c), .in_dm_data(in_dm_data), .in_rd(in_rd),
    .in_regw(in_regw), .in_mem2r(in_mem2r), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_c(out_alu_c), .out_dm_data(out_dm_data), .out_rd(out_rd),
    .out_regw(out_regw), .out_mem2r(out_mem2r), .out_instr(out_instr),
    .out_wb_data(out_wb_data), .rf_we(rf_we), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] dm;
    logic [4:0]  rd;
    logic        regw;
    logic        mem2r;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  bit   m_rdy;
  int   m_cnt;
  int   n_checks = 0;
  int   n_pass = 0;

  // Expected observable state derived from the FIFO model
  function automatic logic [VW-1:0] exp_vec();
    ent_t e;
    logic we;
    logic [31:0] wb;
    logic [3:0] c;
    c = 4'(m_cnt % 16);
    if (q.size() == 0) return {1'b0, m_rdy, 1'b0, 1'b0, c, 172'd0};
    e = q[0];
    wb = e.mem2r ? e.dm : e.alu;
    we = e.regw && (e.rd != 5'd0);
    return {1'b1, m_rdy, we, we, c, e.rd, wb, e.alu, e.dm, e.regw, e.mem2r, e.instr, e.rd, wb};
  endfunction

  // Observed state; data fields are don't-care while out_valid is low
  function automatic logic [VW-1:0] act_vec();
    logic [171:0] f;
    f = {out_rd, out_wb_data, out_alu_c, out_dm_data, out_regw, out_mem2r, out_instr, fwd_rd, fwd_data};
    if (out_valid !== 1'b1) f = '0;
    return {out_valid, in_ready, rf_we, fwd_valid, retired_cnt, f};
  endfunction

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] dm,
                        input logic [4:0] rd, input logic regw, input logic mem2r);
    in_valid = v; in_alu_c = alu; in_dm_data = dm; in_rd = rd;
    in_regw = regw; in_mem2r = mem2r; in_instr = $urandom;
  endtask

  // One clock: advance the model with the inputs presented before the edge
  task automatic tick();
    bit acc, pop, fl;
    ent_t e;
    acc = in_valid && m_rdy;
    pop = (q.size() > 0) && out_ready;
    fl = flush;
    e.alu = in_alu_c; e.dm = in_dm_data; e.rd = in_rd;
    e.regw = in_regw; e.mem2r = in_mem2r; e.instr = in_instr;
    @(posedge clk);
    #1;
    if (pop) begin
      q.delete(0);
      m_cnt++;
    end
    if (fl) q.delete();
    else if (acc) q.push_back(e);
    m_rdy = (q.size() < 2);
  endtask

  task automatic do_reset();
    flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); m_rdy = 1'b1; m_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, rf_we, fwd_valid, retired_cnt, out_alu_c, out_dm_data, out_rd, out_regw,
         out_mem2r, out_instr, out_wb_data, fwd_rd, fwd_data} !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_state: got valid=%b rdy=%b we=%b cnt=%0d alu=%h wb=%h, want all 0 and rdy=1",
               out_valid, in_ready, rf_we, retired_cnt, out_alu_c, out_wb_data);
    else n_pass++;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_in(1'b1, 32'h10 + 32'(i), $urandom, 5'(i + 1), 1'b1, 1'b0);
      else in_valid = 1'b0;
      tick();
      n_checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL streaming[%0d]: got %h want %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (retired_cnt !== 4'd4 || in_ready !== 1'b1)
      $display("FAIL streaming_cnt: got cnt=%0d rdy=%b want cnt=4 rdy=1", retired_cnt, in_ready);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] want [3];
    want[0] = 32'hB; want[1] = 32'hC; want[2] = 32'hC;
    do_reset();
    set_in(1'b1, 32'hA, 32'h0, 5'd1, 1'b1, 1'b0); tick();
    set_in(1'b1, 32'hB, 32'h0, 5'd2, 1'b1, 1'b0); tick();
    set_in(1'b1, 32'hC, 32'h0, 5'd3, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec() || in_ready !== 1'b0 || out_alu_c !== 32'hA)
        $display("FAIL backpressure_hold[%0d]: got rdy=%b alu=%h want rdy=0 alu=a", i, in_ready, out_alu_c);
      else n_pass++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      n_checks++;
      if (act_vec() !== exp_vec() || (i < 2 && out_alu_c !== want[i]))
        $display("FAIL backpressure_drain[%0d]: got %h want %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (retired_cnt !== 4'd3 || out_valid !== 1'b0)
      $display("FAIL backpressure_cnt: got cnt=%0d valid=%b want cnt=3 valid=0", retired_cnt, out_valid);
    else n_pass++;
  endtask

  task automatic test_mem2r_zero_rd();
    do_reset();
    set_in(1'b1, 32'h4, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1); tick();
    n_checks++;
    if (out_wb_data !== 32'hDEADBEEF || fwd_data !== 32'hDEADBEEF || rf_we !== 1'b1)
      $display("FAIL mem2r_wb: got wb=%h fwd=%h we=%b want deadbeef deadbeef 1", out_wb_data, fwd_data, rf_we);
    else n_pass++;
    out_ready = 1'b1;
    set_in(1'b1, 32'h55, 32'h66, 5'd0, 1'b1, 1'b0); tick();
    in_valid = 1'b0;
    n_checks++;
    if (act_vec() !== exp_vec() || out_valid !== 1'b1 || rf_we !== 1'b0 || fwd_valid !== 1'b0)
      $display("FAIL zero_rd: got valid=%b we=%b fwd=%b want 1 0 0", out_valid, rf_we, fwd_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, 32'h1, 32'h0, 5'd1, 1'b1, 1'b0); tick();
    set_in(1'b1, 32'h2, 32'h0, 5'd2, 1'b1, 1'b0); tick();
    set_in(1'b1, 32'h3, 32'h0, 5'd3, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rf_we !== 1'b0 || retired_cnt !== 4'd0)
      $display("FAIL flush: got valid=%b rdy=%b we=%b cnt=%0d want 0 1 0 0", out_valid, in_ready, rf_we, retired_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if (act_vec() !== exp_vec() || out_valid !== 1'b0)
      $display("FAIL flush_drop: got valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1'b1, 32'h77, 32'h88, 5'd9, 1'b1, 1'b0); tick();
    set_in(1'b1, 32'h99, 32'haa, 5'd10, 1'b1, 1'b0); tick();
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || rf_we !== 1'b0 || in_ready !== 1'b1 || fwd_valid !== 1'b0 ||
        {out_alu_c, out_dm_data, out_rd, out_regw, out_instr, out_wb_data} !== '0)
      $display("FAIL async_reset: got valid=%b we=%b rdy=%b alu=%h rd=%0d want 0 0 1 0 0",
               out_valid, rf_we, in_ready, out_alu_c, out_rd);
    else n_pass++;
    #2 rst = 1'b0;
    q.delete(); m_rdy = 1'b1; m_cnt = 0;
    tick();
    n_checks++;
    if (act_vec() !== exp_vec())
      $display("FAIL async_reset_after: got %h want %h", act_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) set_in(1'b1, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      else in_valid = 1'b0;
      tick();
    end
    n_checks++;
    if (retired_cnt !== 4'd1 || act_vec() !== exp_vec())
      $display("FAIL counter_wrap: got cnt=%0d want 1", retired_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_mem2r_zero_rd();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
Parametrised MEM->WB pipeline boundary. It replaces the fixed always-load stage register with a valid/ready handshake and a one-entry skid buffer, so back-pressure from write-back never drops or duplicates an instruction. It also adds:
- a synchronous flush
- a precomputed write-back data path
- a register-file write enable gated by valid and by a zero destination register
- a bypass port toward EX
- a retired-instruction counter

Parameters:
DW, 32, width of ALU result, data-memory read data and write-back data
RW, 5, register-address width
IW, 32, instruction word width, carried through for trace and debug
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_alu_c  in  DW  ALU result
in_dm_data  in  DW  data-memory read data
in_rd  in  RW  destination register
in_regw  in  1  register-write control
in_mem2r  in  1  1 = write back memory data, 0 = write back ALU result
in_instr  in  IW  instruction word
out_valid  out  1  output register holds a live instruction
out_ready  in  1  WB consumes this cycle
out_alu_c  out  DW  held ALU result
out_dm_data  out  DW  held memory data
out_rd  out  RW  held destination register
out_regw  out  1  held register-write control
out_mem2r  out  1  held mem-to-reg control
out_instr  out  IW  held instruction word
out_wb_data  out  DW  registered write-back value
rf_we  out  1  out_valid & out_regw & (out_rd != 0); combinational from registers
fwd_valid  out  1  equals rf_we
fwd_rd  out  RW  equals out_rd
fwd_data  out  DW  equals out_wb_data
retired_cnt  out  CNT_W  count of instructions consumed by WB

Behaviour:
Storage:
- Output register (OUT): all out_* fields, out_wb_data and out_valid.
- Skid register (SKID): same fields plus skid_valid.
- Both capture out_wb_data = mem2r ? dm_data : alu_c at capture time; zero extra latency.

Reset (async):
- out_valid=0, skid_valid=0, in_ready=1, retired_cnt=0.
- All data and control fields reset to 0, including out_wb_data.
- rf_we=0 and fwd_valid=0.

Definitions:
- acc = in_valid & in_ready
- pop = out_valid & out_ready
- Latency is 1 cycle from acc to out_valid when the stage is empty or popping.

Per-clock update, when flush=0:
- acc=1 and (!out_valid or pop): input loads OUT; out_valid=1.
- acc=1, out_valid=1 and !pop: input loads SKID; skid_valid=1, so in_ready=0 next cycle.
- acc=0 and pop=1: if skid_valid, SKID moves to OUT and skid_valid=0; else out_valid=0.
- skid_valid=1 and pop=1: SKID moves to OUT. in_ready is 0 here, so no simultaneous accept is possible.
- Otherwise hold all state.

Flush:
- flush=1: out_valid=0 and skid_valid=0 next edge; in_ready=1 next cycle.
- A simultaneous acc is dropped.
- A simultaneous pop still counts as retired, because WB sampled it this cycle.
- Data fields of killed entries hold their values; they are don't-care while invalid.

Counter and invariants:
- retired_cnt increments by 1 on every pop and wraps modulo 2^CNT_W. Flush does not clear it.
- Invalid entries never assert rf_we or fwd_valid, regardless of the stored regw.
- Ordering is strict FIFO: SKID is always younger than OUT.
- Never skid_valid=1 while out_valid=0.

Mid-operation reset: everything clears immediately and asynchronously, with no pending writes.

Test Plan:
1. Streaming: out_ready=1; send 4 instructions back-to-back (rd=1..4, alu_c=0x10..0x13, mem2r=0, regw=1) -> each appears one cycle later; out_wb_data=alu_c; rf_we=1 every cycle; in_ready stays 1; retired_cnt=4.
2. Back-pressure: hold out_ready=0 and send A(alu_c=0xA) then B(alu_c=0xB) -> OUT=A, SKID=B, in_ready=0; C is held at the input. Release out_ready -> outputs A, B, C in order, no loss or duplication; retired_cnt=3.
3. Mem-to-reg and zero rd: mem2r=1, dm_data=0xDEADBEEF, alu_c=0x4 -> out_wb_data=0xDEADBEEF. rd=0 with regw=1 -> rf_we=0 and fwd_valid=0, while out_valid=1.
4. Flush with both entries full and a new in_valid asserted -> next cycle out_valid=0, skid_valid=0, in_ready=1; the new input is not captured; retired_cnt unchanged.
5. Async reset asserted between clock edges while full -> out_valid, rf_we and in_ready update immediately to 0, 0, 1; all fields read 0.
6. Counter wrap with CNT_W=4: 17 pops -> retired_cnt=1.
